// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso serialiser.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal flag.
module piso_bit_cnt #(
    parameter int WIDTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] count;

    assign tc = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out shifter, MSB-first, valid/ready word handshake.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             valid_o,
    output logic             sof_o,
    output logic             par_o
);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             dout_d, vld_d, sof_d, par_d;
    logic             accept, tc;

    assign accept = valid_i && ready_o;

`ifdef PISO_PARITY_EN
    logic par_q;
    assign ready_o = (state_q == IDLE) || (state_q == PARITY);
`else
    assign ready_o = (state_q == IDLE) || (state_q == SHIFT && tc);
`endif

    piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (accept),
        .en      (state_q == SHIFT),
        .tc      (tc)
    );

    // Outputs are computed from the next state so the MSB shows the cycle after accept.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        sof_d   = 1'b0;
        par_d   = 1'b0;
        unique case (1'b1)
            accept: begin
                state_d = SHIFT;
                sr_d    = {data_i[WIDTH-2:0], 1'b0};
                dout_d  = data_i[WIDTH-1];
                vld_d   = 1'b1;
                sof_d   = 1'b1;
            end
            (state_q == SHIFT && !tc): begin
                sr_d   = {sr_q[WIDTH-2:0], 1'b0};
                dout_d = sr_q[WIDTH-1];
                vld_d  = 1'b1;
            end
            (state_q == SHIFT && tc && !accept): begin
`ifdef PISO_PARITY_EN
                state_d = PARITY;
                dout_d  = par_q;
                vld_d   = 1'b1;
                par_d   = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_o  <= 1'b0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_o  <= dout_d;
            valid_o <= vld_d;
            sof_o   <= sof_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            par_q <= 1'b0;
            par_o <= 1'b0;
        end else begin
            if (accept) begin
                par_q <= ^data_i;
            end
            par_o <= par_d;
        end
    end
`else
    assign par_o = 1'b0;
    logic unused_par;
    assign unused_par = par_d;
`endif

endmodule

// File: tb/tb_piso.sv
// Scoreboard bench for piso: accepted words expand into expected bit queue.
module tb_piso;
    import piso_pkg::*;

    localparam int W = PISO_WIDTH_DEF;

    typedef struct packed {
        logic d;
        logic s;
        logic p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         ready_o, data_o, valid_o, sof_o, par_o;

    exp_t q[$];
    int   cmps = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;

    piso #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sof_o   (sof_o),
        .par_o   (par_o)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expected bit per valid output, checks ready against backlog.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (mon_en) begin
            got = '{data_o, sof_o, par_o};
            if (valid_o) begin
                cmps++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL extra_bit: got d/s/p=%b expected no valid bit", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errs++;
                        $display("FAIL bit: got d/s/p=%b expected %b", got, e);
                    end
                end
            end else begin
                cmps++;
                if (q.size() != 0 || got !== 3'b000 || valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL idle: got v=%b d/s/p=%b pending=%0d expected all 0, pending 0",
                             valid_o, got, q.size());
                end
            end
            cmps++;
            if (ready_o !== (q.size() == 0)) begin
                errs++;
                $display("FAIL ready: got %b expected %b", ready_o, q.size() == 0);
            end
            if (!rst_n_i) begin
                q.delete();
            end else if (valid_i && ready_o) begin
                for (int k = W - 1; k >= 0; k--) begin
                    q.push_back('{data_i[k], (k == W - 1), 1'b0});
                end
`ifdef PISO_PARITY_EN
                q.push_back('{^data_i, 1'b0, 1'b1});
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        valid_i = 1'b1;
        data_i = w;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = ready_o && rst_n_i;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        data_i = W'($urandom);
        cmps++;
        if (!acc) begin
            errs++;
            $display("FAIL accept_timeout: word %h not accepted after %0d cycles, expected accept", w, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            data_i = W'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmps++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d bits pending expected 0", q.size());
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        idle(3);

        send(4'hA);
        drain();
        idle(2);

        send(4'hA);
        send(4'h5);
        drain();
        idle(2);

        send(4'hC);
        send(4'h3);
        drain();
        idle(2);

        // Reset two bits into a word: remaining bits must be dropped.
        send(4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        idle(6);

        for (int i = 0; i < 40; i++) begin
            send(W'($urandom));
            if (i == 20) begin
                @(posedge clk);
                #1;
                rst_n_i = 1'b0;
                @(posedge clk);
                #1;
                rst_n_i = 1'b1;
            end
            idle($urandom_range(0, 2));
        end
        drain();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
